pdm_modulator: RTL and testbench

Playback-side counterpart of the PDM microphone decimator: accepts signed 16-bit PCM samples at clk/R through a valid/ready handshake and converts them to a 1-bit PDM stream with a second-order sigma-delta modulator. Driven from the same PDM clock as the capture path. `pdm_out` feeds an RC low-pass filter and amplifier to reproduce the karaoke audio.

---
 rtl/pdm_modulator.sv | 127 ++++++++++++
 tb/tb_pdm_modulator.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_modulator.sv
// Second-order sigma-delta PDM modulator fed by a one-deep PCM holding buffer.
// Optional LFSR dither on the modulator input when PDM_MODULATOR_DITHER_EN is defined.
module pdm_modulator #(
    parameter int R         = 24,
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [IN_WIDTH-1:0] din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic                       pdm_out,
    output logic                       sample_tick,
    output logic                       underrun
);
    localparam int PW = $clog2(R);
    // Two guard bits hold any sum of two integrators plus feedback without overflow
    localparam int EW = ACC_WIDTH + 2;
    localparam logic [PW-1:0]        PHASE_LAST = PW'(R - 1);
    localparam logic signed [EW-1:0] ACC_MAX    = EW'((longint'(1) << (ACC_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] ACC_MIN    = EW'(-(longint'(1) << (ACC_WIDTH - 1)));
    localparam logic signed [EW-1:0] FB_POS     = EW'(longint'(1) << (IN_WIDTH - 1));

    function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [EW-1:0] v);
        if (v > ACC_MAX) begin
            return ACC_MAX[ACC_WIDTH-1:0];
        end else if (v < ACC_MIN) begin
            return ACC_MIN[ACC_WIDTH-1:0];
        end
        return v[ACC_WIDTH-1:0];
    endfunction

    logic [PW-1:0]                phase_q, phase_d;
    logic signed [IN_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic                         buf_full_q, buf_full_d;
    logic signed [IN_WIDTH-1:0]   active_q, active_d;
    logic signed [ACC_WIDTH-1:0]  i1_q, i1_d;
    logic signed [ACC_WIDTH-1:0]  i2_q, i2_d;
    logic                         pdm_q, pdm_d;
    logic                         tick_q, tick_d;
    logic                         underrun_q, underrun_d;
    logic signed [EW-1:0]         x_ext;
    logic signed [EW-1:0]         fb;

    assign din_ready   = ~buf_full_q;
    assign pdm_out     = pdm_q;
    assign sample_tick = tick_q;
    assign underrun    = underrun_q;

`ifdef PDM_MODULATOR_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        x_ext  = EW'(active_q) + EW'($signed(lfsr_q[1:0]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        x_ext = EW'(active_q);
    end
`endif

    always_comb begin
        phase_d    = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
        buf_data_d = buf_data_q;
        buf_full_d = buf_full_q;
        active_d   = active_q;
        tick_d     = 1'b0;
        underrun_d = 1'b0;

        if (phase_q == PHASE_LAST) begin
            tick_d = 1'b1;
            if (buf_full_q) begin
                active_d   = buf_data_q;
                buf_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // Evaluated after the wrap so an empty buffer at the wrap still accepts
        if (din_valid && din_ready) begin
            buf_data_d = din;
            buf_full_d = 1'b1;
        end
    end

    always_comb begin
        fb    = pdm_q ? FB_POS : -FB_POS;
        i1_d  = sat(EW'(i1_q) + x_ext - fb);
        i2_d  = sat(EW'(i2_q) + EW'(i1_q) - fb);
        pdm_d = ~i2_d[ACC_WIDTH-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q    <= '0;
            buf_data_q <= '0;
            buf_full_q <= 1'b0;
            active_q   <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            pdm_q      <= 1'b0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            buf_data_q <= buf_data_d;
            buf_full_q <= buf_full_d;
            active_q   <= active_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            pdm_q      <= pdm_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
        end
    end
endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator: handshake timing, density, underrun, reset and dither.
module tb_pdm_modulator;
    localparam int R = 24;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [15:0] din = '0;
    logic               din_valid = 1'b0;
    logic               din_ready;
    logic               pdm_out;
    logic               sample_tick;
    logic               underrun;

    int checks = 0;
    int failures = 0;

    // Idle limit cycle for a zero input, starting at the first edge after reset
    logic [7:0] idle_pat = 8'b1110_0001;

    int         m_i1, m_i2;
    logic       m_pdm;
    logic [15:0] m_lfsr;

    pdm_modulator #(.R(R), .IN_WIDTH(16), .ACC_WIDTH(24)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .pdm_out     (pdm_out),
        .sample_tick (sample_tick),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    function automatic int sat24(input int v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    task automatic model_reset();
        m_i1   = 0;
        m_i2   = 0;
        m_pdm  = 1'b0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_step(input int active);
        int x, fb, n1;
        x = active;
`ifdef PDM_MODULATOR_DITHER_EN
        case (m_lfsr[1:0])
            2'd0: x = x + 0;
            2'd1: x = x + 1;
            2'd2: x = x - 2;
            default: x = x - 1;
        endcase
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`endif
        fb    = m_pdm ? 32768 : -32768;
        n1    = sat24(m_i1 + x - fb);
        m_i2  = sat24(m_i2 + m_i1 - fb);
        m_i1  = n1;
        m_pdm = (m_i2 >= 0);
    endtask

    // Releases reset on a falling edge, so the next rising edge is edge 1
    task automatic apply_reset(input int cycles);
        reset_n   = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({pdm_out, sample_tick, underrun, din_ready} !== 4'b0001) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got pdm/tick/under/ready=%b expected 0001",
                         c, {pdm_out, sample_tick, underrun, din_ready});
            end
        end
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (pdm_out !== idle_pat[7-k]) begin
                failures++;
                $display("FAIL first_pdm edge=%0d got %b expected %b", k + 1, pdm_out, idle_pat[7-k]);
            end
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_handshake();
        int accepts;
        apply_reset(2);
        din       = 16'sh4000;
        din_valid = 1'b1;
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL hs_ready_initial got %b expected 1", din_ready);
        end
        for (int e = 1; e <= R + 1; e++) begin
            @(negedge clk);
            checks++;
            if (sample_tick !== ((e == R) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL hs_tick edge=%0d got %b expected %b", e, sample_tick, (e == R));
            end
            checks++;
            if (din_ready !== ((e == R) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL hs_ready edge=%0d got %b expected %b", e, din_ready, (e == R));
            end
            if (e == R) begin
                checks++;
                if (underrun !== 1'b0) begin
                    failures++;
                    $display("FAIL hs_no_underrun got %b expected 0", underrun);
                end
            end
        end
        accepts = 0;
        repeat (10 * R) begin
            @(negedge clk);
            if (din_valid && din_ready) accepts++;
        end
        checks++;
        if (accepts != 10) begin
            failures++;
            $display("FAIL hs_accept_rate got %0d accepts expected 10", accepts);
        end
        din_valid = 1'b0;
        $display("test_handshake done accepts=%0d", accepts);
    endtask

    task automatic density_run(input logic signed [15:0] val, input int lo, input int hi,
                               input string name);
        int ones, unders;
        apply_reset(2);
        din       = val;
        din_valid = 1'b1;
        unders    = 0;
        repeat (R + 2) begin
            @(negedge clk);
            unders += int'(underrun);
        end
        ones = 0;
        repeat (1024) begin
            @(negedge clk);
            ones   += int'(pdm_out);
            unders += int'(underrun);
        end
        checks++;
        if (ones < lo || ones > hi) begin
            failures++;
            $display("FAIL density_%s got %0d ones expected %0d..%0d", name, ones, lo, hi);
        end
        checks++;
        if (unders != 0) begin
            failures++;
            $display("FAIL density_%s_underrun got %0d pulses expected 0", name, unders);
        end
        din_valid = 1'b0;
        $display("density %s ones=%0d", name, ones);
    endtask

    task automatic test_density();
        density_run(16'sh7FFF, 1020, 1024, "pos_full");
        density_run(16'sh8000, 0, 4, "neg_full");
        density_run(16'sh0000, 504, 520, "zero");
    endtask

    task automatic test_underrun();
        int ones, unders, ticks;
        apply_reset(2);
        din       = 16'sh4000;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int e = 2; e <= 2 * R + 1; e++) begin
            @(negedge clk);
            if (e == R || e == 2 * R || e == 2 * R + 1) begin
                checks++;
                if (sample_tick !== ((e == 2 * R + 1) ? 1'b0 : 1'b1)) begin
                    failures++;
                    $display("FAIL ur_tick edge=%0d got %b expected %b", e, sample_tick, (e != 2 * R + 1));
                end
            end
            checks++;
            if (underrun !== ((e == 2 * R) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL ur_pulse edge=%0d got %b expected %b", e, underrun, (e == 2 * R));
            end
        end
        ones = 0; unders = 0; ticks = 0;
        repeat (1024) begin
            @(negedge clk);
            ones   += int'(pdm_out);
            unders += int'(underrun);
            ticks  += int'(sample_tick);
        end
        checks++;
        if (ones < 760 || ones > 776) begin
            failures++;
            $display("FAIL ur_density got %0d ones expected 760..776", ones);
        end
        checks++;
        if (unders != 42 || ticks != 42) begin
            failures++;
            $display("FAIL ur_count got underrun=%0d tick=%0d expected 42/42", unders, ticks);
        end
        $display("test_underrun done ones=%0d underruns=%0d", ones, unders);
    endtask

    task automatic test_reset_midstream();
        int errs;
        apply_reset(2);
        din       = 16'sh4000;
        din_valid = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (din_ready !== 1'b0 || pdm_out !== 1'b1) begin
            failures++;
            $display("FAIL mid_precond got ready=%b pdm=%b expected 0/1", din_ready, pdm_out);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({din_ready, pdm_out, sample_tick, underrun} !== 4'b1000) begin
            failures++;
            $display("FAIL mid_async_clear got ready/pdm/tick/under=%b expected 1000",
                     {din_ready, pdm_out, sample_tick, underrun});
        end
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        din  = 16'sh1234;
        errs = 0;
        for (int k = 1; k <= 4 * R; k++) begin
            @(negedge clk);
            model_step((k > 2 * R) ? 4660 : 0);
            if (pdm_out !== m_pdm) begin
                errs++;
                if (errs <= 4)
                    $display("FAIL mid_pdm edge=%0d got %b expected %b", k, pdm_out, m_pdm);
            end
            if (k == R) begin
                checks++;
                if (underrun !== 1'b1) begin
                    failures++;
                    $display("FAIL mid_dropped_sample got underrun=%b expected 1", underrun);
                end
            end
            din_valid = (k == R);
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL mid_bit_exact got %0d mismatching bits expected 0", errs);
        end
        $display("test_reset_midstream done");
    endtask

`ifdef PDM_MODULATOR_DITHER_EN
    task automatic test_dither();
        int errs, ones, deviate;
        apply_reset(2);
        errs = 0; ones = 0; deviate = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            model_step(0);
            ones += int'(pdm_out);
            if (pdm_out !== m_pdm) errs++;
            if (pdm_out !== idle_pat[7 - (k % 8)]) deviate++;
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL dither_bit_exact got %0d mismatching bits expected 0", errs);
        end
        checks++;
        if (ones < 504 || ones > 520) begin
            failures++;
            $display("FAIL dither_density got %0d ones expected 504..520", ones);
        end
        checks++;
        if (deviate == 0) begin
            failures++;
            $display("FAIL dither_pattern got pure period-8 idle pattern expected deviation");
        end
        $display("test_dither done ones=%0d deviations=%0d", ones, deviate);
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_handshake();
        test_density();
        test_underrun();
        test_reset_midstream();
`ifdef PDM_MODULATOR_DITHER_EN
        test_dither();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
